// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: picks one functional unit per cycle by starvation, then
// branch round-robin, then plain round-robin, and keeps grant status and utilisation.
module cdb_arbiter #(
    parameter int N_REQ        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ-1:0]         is_branch_i,
    input  logic                     stall_i,
    input  logic                     squash_i,
    output logic [N_REQ-1:0]         grant_o,
    output logic                     grant_valid_o,
    output logic [$clog2(N_REQ)-1:0] grant_idx_o,
    output logic [$clog2(N_REQ)-1:0] last_grant_idx_o,
    output logic                     forced_grant_o,
    output logic [31:0]              busy_cycles_o
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam int IW = $clog2(N_REQ);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [IW-1:0] rr_q, rr_d;
    logic [CW-1:0] wait_q [N_REQ];
    logic [CW-1:0] wait_d [N_REQ];
    logic [IW-1:0] last_q, last_d;
    logic          forced_q, forced_d;
    logic [31:0]   busy_q, busy_d;

    logic          st_found, br_found, rr_found, block;
    logic [IW-1:0] st_idx, br_idx, rr_idx, sel_idx;
    logic [N_REQ-1:0] br_req;
    int            pos;

    assign block  = reset_i | squash_i | stall_i;
    assign br_req = req_i & is_branch_i;

    // Descending scans so the lowest index / nearest-to-pointer candidate is written last.
    always_comb begin
        st_found = 1'b0;
        st_idx   = '0;
        br_found = 1'b0;
        br_idx   = '0;
        rr_found = 1'b0;
        rr_idx   = '0;
        pos      = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_i[i] && wait_q[i] == LIMIT) begin
                st_found = 1'b1;
                st_idx   = IW'(i);
            end
        end
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = int'(rr_q) + k;
            if (pos >= N_REQ) pos = pos - N_REQ;
            if (br_req[pos]) begin
                br_found = 1'b1;
                br_idx   = IW'(pos);
            end
            if (req_i[pos]) begin
                rr_found = 1'b1;
                rr_idx   = IW'(pos);
            end
        end
    end

    always_comb begin
        grant_valid_o = 1'b0;
        sel_idx       = '0;
        forced_d      = 1'b0;
        if (!block) begin
            if (st_found) begin
                grant_valid_o = 1'b1;
                sel_idx       = st_idx;
                forced_d      = 1'b1;
            end else if (br_found) begin
                grant_valid_o = 1'b1;
                sel_idx       = br_idx;
            end else if (rr_found) begin
                grant_valid_o = 1'b1;
                sel_idx       = rr_idx;
            end
        end
    end

    assign grant_idx_o = sel_idx;
    assign grant_o     = grant_valid_o ? (N_REQ'(1) << sel_idx) : '0;

    always_comb begin
        rr_d   = rr_q;
        last_d = last_q;
        busy_d = busy_q + 32'(grant_valid_o);
        if (squash_i) begin
            rr_d = '0;
        end else if (grant_valid_o) begin
            rr_d = (sel_idx == IW'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;
        end
        if (grant_valid_o) last_d = sel_idx;
    end

    // Stalled cycles neither age nor clear a pending request.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_wait
        assign wait_d[gi] = squash_i                    ? '0 :
                            (!req_i[gi] || grant_o[gi]) ? '0 :
                            stall_i                     ? wait_q[gi] :
                            (wait_q[gi] == LIMIT)       ? LIMIT :
                                                          wait_q[gi] + 1'b1;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rr_q     <= '0;
            last_q   <= '0;
            forced_q <= 1'b0;
            busy_q   <= '0;
            for (int i = 0; i < N_REQ; i++) wait_q[i] <= '0;
        end else begin
            rr_q     <= rr_d;
            last_q   <= last_d;
            forced_q <= forced_d;
            busy_q   <= busy_d;
            for (int i = 0; i < N_REQ; i++) wait_q[i] <= wait_d[i];
        end
    end

    assign last_grant_idx_o = last_q;
    assign forced_grant_o   = forced_q;
    assign busy_cycles_o    = busy_q;

    a_grant_ok: assert property (@(posedge clock_i)
        $onehot0(grant_o) && ((grant_o & ~req_i) == '0));

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vectors with literal expectations plus a
// rule-level reference model compared against every output on every cycle.
module tb_cdb_arbiter;
    localparam int N  = 4;
    localparam int SL = 3;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [3:0]  req_i = '0;
    logic [3:0]  is_branch_i = '0;
    logic        stall_i = 1'b0;
    logic        squash_i = 1'b0;
    logic [3:0]  grant_o;
    logic        grant_valid_o;
    logic [1:0]  grant_idx_o;
    logic [1:0]  last_grant_idx_o;
    logic        forced_grant_o;
    logic [31:0] busy_cycles_o;

    int checks = 0;
    int errors = 0;

    cdb_arbiter #(.N_REQ(N), .STARVE_LIMIT(SL)) dut (
        .clock_i          (clk),
        .reset_i          (reset_i),
        .req_i            (req_i),
        .is_branch_i      (is_branch_i),
        .stall_i          (stall_i),
        .squash_i         (squash_i),
        .grant_o          (grant_o),
        .grant_valid_o    (grant_valid_o),
        .grant_idx_o      (grant_idx_o),
        .last_grant_idx_o (last_grant_idx_o),
        .forced_grant_o   (forced_grant_o),
        .busy_cycles_o    (busy_cycles_o)
    );

    always #5 clk = ~clk;

    // Reference model state
    int          m_rr = 0;
    int          m_wait [N];
    int          m_last = 0;
    bit          m_forced = 1'b0;
    int unsigned m_busy = 0;
    bit          primed = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_pick(output bit forced);
        forced = 1'b0;
        if (reset_i || squash_i || stall_i) return -1;
        for (int i = 0; i < N; i++)
            if (req_i[i] && m_wait[i] == SL) begin
                forced = 1'b1;
                return i;
            end
        for (int k = 0; k < N; k++)
            if (req_i[(m_rr + k) % N] && is_branch_i[(m_rr + k) % N]) return (m_rr + k) % N;
        for (int k = 0; k < N; k++)
            if (req_i[(m_rr + k) % N]) return (m_rr + k) % N;
        return -1;
    endfunction

    always @(negedge clk) begin
        int  idx;
        bit  f;
        logic [3:0] eg;
        idx = model_pick(f);
        eg  = (idx >= 0) ? 4'(1 << idx) : 4'b0;
        chk("m_grant", 32'(grant_o), 32'(eg));
        chk("m_grant_valid", 32'(grant_valid_o), 32'(idx >= 0));
        chk("m_grant_idx", 32'(grant_idx_o), (idx >= 0) ? 32'(idx) : 32'd0);
        if (primed) begin
            chk("m_last_grant_idx", 32'(last_grant_idx_o), 32'(m_last));
            chk("m_forced_grant", 32'(forced_grant_o), 32'(m_forced));
            chk("m_busy_cycles", busy_cycles_o, m_busy);
        end
        $display("cyc t=%0t rst=%0b req=%b br=%b st=%0b sq=%0b grant=%b exp=%b busy=%0d",
                 $time, reset_i, req_i, is_branch_i, stall_i, squash_i, grant_o, eg, busy_cycles_o);
        if (reset_i) begin
            m_rr = 0; m_last = 0; m_forced = 0; m_busy = 0;
            for (int i = 0; i < N; i++) m_wait[i] = 0;
            primed = 1'b1;
        end else begin
            m_forced = f && (idx >= 0);
            if (idx >= 0) begin
                m_busy++;
                m_last = idx;
            end
            for (int i = 0; i < N; i++) begin
                if (squash_i || !req_i[i] || (idx == i)) m_wait[i] = 0;
                else if (!stall_i && m_wait[i] < SL) m_wait[i]++;
            end
            if (squash_i) m_rr = 0;
            else if (idx >= 0) m_rr = (idx + 1) % N;
        end
    end

    task automatic step(input logic rst, input logic [3:0] r, input logic [3:0] b,
                        input logic st, input logic sq);
        @(posedge clk);
        #1;
        reset_i = rst; req_i = r; is_branch_i = b; stall_i = st; squash_i = sq;
        #1;
    endtask

    typedef struct { logic [3:0] r; logic [3:0] b; logic st; logic sq; } vec_t;
    vec_t tbl [12];

    initial begin
        tbl[0]  = '{4'b1100, 4'b1100, 1'b0, 1'b0};
        tbl[1]  = '{4'b1111, 4'b1100, 1'b0, 1'b0};
        tbl[2]  = '{4'b1111, 4'b1100, 1'b0, 1'b0};
        tbl[3]  = '{4'b1111, 4'b1100, 1'b0, 1'b0};
        tbl[4]  = '{4'b1111, 4'b1100, 1'b0, 1'b0};
        tbl[5]  = '{4'b1111, 4'b0000, 1'b0, 1'b0};
        tbl[6]  = '{4'b1111, 4'b0000, 1'b0, 1'b0};
        tbl[7]  = '{4'b1111, 4'b0000, 1'b1, 1'b1};
        tbl[8]  = '{4'b0010, 4'b1101, 1'b0, 1'b0};
        tbl[9]  = '{4'b1010, 4'b0000, 1'b1, 1'b0};
        tbl[10] = '{4'b1010, 4'b0000, 1'b0, 1'b0};
        tbl[11] = '{4'b0000, 4'b1111, 1'b0, 1'b0};

        step(1, 4'h0, 4'h0, 0, 0);
        step(1, 4'h0, 4'h0, 0, 0);

        // Plain round-robin over all four
        step(0, 4'hF, 4'h0, 0, 0); chk("t1_g0", 32'(grant_o), 32'h1);
        step(0, 4'hF, 4'h0, 0, 0); chk("t1_g1", 32'(grant_o), 32'h2);
        step(0, 4'hF, 4'h0, 0, 0); chk("t1_g2", 32'(grant_o), 32'h4);
        step(0, 4'hF, 4'h0, 0, 0); chk("t1_g3", 32'(grant_o), 32'h8);
        step(0, 4'h0, 4'h0, 0, 0); chk("t1_busy", busy_cycles_o, 32'd4);

        // Branch priority
        step(0, 4'h0, 4'h0, 0, 1); chk("t2_squash", 32'(grant_o), 32'h0);
        step(0, 4'h5, 4'h4, 0, 0); chk("t2_branch", 32'(grant_o), 32'h4);
        step(0, 4'h1, 4'h0, 0, 0); chk("t2_next", 32'(grant_o), 32'h1);

        // Starvation of a non-branch requester
        step(0, 4'h0, 4'h0, 0, 1);
        step(0, 4'hE, 4'hC, 0, 0); chk("t3_c1", 32'(grant_o), 32'h4);
        step(0, 4'hE, 4'hC, 0, 0); chk("t3_c2", 32'(grant_o), 32'h8);
        step(0, 4'hE, 4'hC, 0, 0); chk("t3_c3", 32'(grant_o), 32'h4);
        step(0, 4'hE, 4'hC, 0, 0); chk("t3_forced", 32'(grant_o), 32'h2);
        step(0, 4'h0, 4'h0, 0, 0); chk("t3_forced_flag", 32'(forced_grant_o), 32'h1);
        chk("t3_last", 32'(last_grant_idx_o), 32'h1);

        // Stall holds everything
        for (int i = 0; i < 5; i++) begin
            step(0, 4'h3, 4'h0, 1, 0); chk("t4_stall", 32'(grant_o), 32'h0);
        end
        step(0, 4'h3, 4'h0, 0, 0); chk("t4_release", 32'(grant_o), 32'h1);
        step(0, 4'h0, 4'h0, 0, 0); chk("t4_busy", busy_cycles_o, 32'd11);

        // Squash mid-arbitration with rr_ptr=2 and a waiting requester
        step(0, 4'h3, 4'h0, 0, 0); chk("t5_pre", 32'(grant_o), 32'h2);
        step(0, 4'hF, 4'h0, 0, 1); chk("t5_squash", 32'(grant_o), 32'h0);
        step(0, 4'hC, 4'h0, 0, 0); chk("t5_after", 32'(grant_o), 32'h4);

        // Mixed directed vectors, checked by the model
        for (int i = 0; i < 12; i++) step(0, tbl[i].r, tbl[i].b, tbl[i].st, tbl[i].sq);

        // Reset while requesting
        step(1, 4'hF, 4'h0, 0, 0); chk("t6_rst_grant", 32'(grant_o), 32'h0);
        chk("t6_rst_valid", 32'(grant_valid_o), 32'h0);
        step(1, 4'hF, 4'h0, 0, 0);
        step(0, 4'hF, 4'h0, 0, 0); chk("t6_first", 32'(grant_o), 32'h1);
        chk("t6_last", 32'(last_grant_idx_o), 32'h0);
        chk("t6_forced", 32'(forced_grant_o), 32'h0);
        chk("t6_busy", busy_cycles_o, 32'h0);
        step(0, 4'h0, 4'h0, 0, 0);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
